// File: rtl/irq_receiver.sv
// irq_receiver: core-side IRQ buffer. Accepts interconnect IRQs into a small FIFO,
// coalesces repeats of pending numbers, and offers the oldest entry to the core.
`default_nettype none

module irq_receiver #(
   parameter int P_FIFO_DEPTH   = 4,
   parameter int P_FIFO_DEPTH_N = 2
) (
   input  logic                      iCLOCK,
   input  logic                      iRESET,
   input  logic                      iFLUSH,
   input  logic                      iIRQ_VALID,
   input  logic [5:0]                iIRQ_NUM,
   output logic                      oIRQ_ACK,
   input  logic                      iCORE_IRQ_ENABLE,
   output logic                      oCORE_IRQ_VALID,
   output logic [5:0]                oCORE_IRQ_NUM,
   input  logic                      iCORE_IRQ_ACK,
   output logic [P_FIFO_DEPTH_N:0]   oPENDING_COUNT,
   output logic                      oCOALESCE
);

   localparam logic [P_FIFO_DEPTH_N:0] c_full_count = (P_FIFO_DEPTH_N+1)'(P_FIFO_DEPTH);
   localparam logic [P_FIFO_DEPTH_N:0] c_ptr_one    = (P_FIFO_DEPTH_N+1)'(1);

   // Pointers carry one extra bit so that full and empty are distinguishable.
   logic [P_FIFO_DEPTH_N:0]   wr_ptr_q, wr_ptr_d;
   logic [P_FIFO_DEPTH_N:0]   rd_ptr_q, rd_ptr_d;
   logic [63:0]               bitmap_q, bitmap_d;
   logic                      b_ack_q, b_ack_d;
   logic                      coal_q, coal_d;
   logic [5:0]                mem_q [P_FIFO_DEPTH];

   logic [P_FIFO_DEPTH_N:0]   w_count;
   logic                      w_nonempty;
   logic [5:0]                w_head;
   logic                      w_pop;
   logic                      w_accept;
   logic                      w_coalesce;
   logic                      w_push;

   assign w_count    = wr_ptr_q - rd_ptr_q;
   assign w_nonempty = (w_count != '0);
   assign w_head     = mem_q[rd_ptr_q[P_FIFO_DEPTH_N-1:0]];

   assign w_pop      = iCORE_IRQ_ENABLE && w_nonempty && iCORE_IRQ_ACK;
   assign w_accept   = iIRQ_VALID && !b_ack_q && (w_count != c_full_count);
   // A pending copy that leaves the FIFO this cycle cannot absorb the new request.
   assign w_coalesce = w_accept && bitmap_q[iIRQ_NUM] && !(w_pop && (w_head == iIRQ_NUM));
   assign w_push     = w_accept && !w_coalesce;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      bitmap_d = bitmap_q;
      b_ack_d  = 1'b0;
      coal_d   = 1'b0;
      if (iFLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         bitmap_d = '0;
      end else begin
         if (w_pop) begin
            rd_ptr_d         = rd_ptr_q + c_ptr_one;
            bitmap_d[w_head] = 1'b0;
         end
         if (w_accept) begin
            b_ack_d = 1'b1;
            coal_d  = w_coalesce;
         end
         // Set after the pop clear so a same-number re-push stays marked pending.
         if (w_push) begin
            wr_ptr_d           = wr_ptr_q + c_ptr_one;
            bitmap_d[iIRQ_NUM] = 1'b1;
         end
      end
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         bitmap_q <= '0;
         b_ack_q  <= 1'b0;
         coal_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         bitmap_q <= bitmap_d;
         b_ack_q  <= b_ack_d;
         coal_q   <= coal_d;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (w_push && !iFLUSH) begin
         mem_q[wr_ptr_q[P_FIFO_DEPTH_N-1:0]] <= iIRQ_NUM;
      end
   end

   assign oIRQ_ACK        = b_ack_q;
   assign oCOALESCE       = coal_q;
   assign oPENDING_COUNT  = w_count;
   assign oCORE_IRQ_VALID = iCORE_IRQ_ENABLE && w_nonempty;
   assign oCORE_IRQ_NUM   = w_nonempty ? w_head : 6'd0;

endmodule

`default_nettype wire

// File: tb/tb_irq_receiver.sv
// tb_irq_receiver: directed table-driven bench for irq_receiver plus hand-written
// sequences for asynchronous reset and pointer wrap-around.
`default_nettype none

module tb_irq_receiver;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       irq_valid;
   logic [5:0] irq_num;
   logic       irq_ack;
   logic       core_en;
   logic       core_valid;
   logic [5:0] core_num;
   logic       core_ack;
   logic [2:0] pend_cnt;
   logic       coal;

   int n_checks = 0;
   int n_pass   = 0;

   irq_receiver #(
      .P_FIFO_DEPTH   (4),
      .P_FIFO_DEPTH_N (2)
   ) dut (
      .iCLOCK           (clk),
      .iRESET           (rst),
      .iFLUSH           (flush),
      .iIRQ_VALID       (irq_valid),
      .iIRQ_NUM         (irq_num),
      .oIRQ_ACK         (irq_ack),
      .iCORE_IRQ_ENABLE (core_en),
      .oCORE_IRQ_VALID  (core_valid),
      .oCORE_IRQ_NUM    (core_num),
      .iCORE_IRQ_ACK    (core_ack),
      .oPENDING_COUNT   (pend_cnt),
      .oCOALESCE        (coal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       flush;
      logic       valid;
      logic [5:0] num;
      logic       en;
      logic       cack;
      logic       e_ack;
      logic       e_cv;
      logic [5:0] e_num;
      logic [2:0] e_cnt;
      logic       e_coal;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic fl, input logic v, input logic [5:0] n, input logic en,
                      input logic ca, input logic eack, input logic ecv, input logic [5:0] enm,
                      input logic [2:0] ecnt, input logic ecoal);
      vec_t r;
      r.flush = fl; r.valid = v; r.num = n; r.en = en; r.cack = ca;
      r.e_ack = eack; r.e_cv = ecv; r.e_num = enm; r.e_cnt = ecnt; r.e_coal = ecoal;
      vq.push_back(r);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ack"},   32'(irq_ack),    32'd0);
      chk({tag, " cv"},    32'(core_valid), 32'd0);
      chk({tag, " cnum"},  32'(core_num),   32'd0);
      chk({tag, " count"}, 32'(pend_cnt),   32'd0);
      chk({tag, " coal"},  32'(coal),       32'd0);
   endtask

   task automatic drive_idle();
      flush = 1'b0; irq_valid = 1'b0; irq_num = 6'd0; core_en = 1'b0; core_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int popped;

      drive_idle();
      rst = 1'b1;

      // flush, valid, num, en, core_ack | ack, cvalid, cnum, count, coalesce
      // single IRQ
      add(0,0,0,1,0, 0,0,0,0,0);
      add(0,1,5,1,0, 0,0,0,0,0);
      add(0,1,5,1,0, 1,1,5,1,0);
      add(0,0,0,1,1, 0,1,5,1,0);
      add(0,0,0,1,0, 0,0,0,0,0);
      // fill with enable low, then backpressure on 6
      add(0,1,1,0,0, 0,0,0,0,0);
      add(0,1,1,0,0, 1,0,1,1,0);
      add(0,1,2,0,0, 0,0,1,1,0);
      add(0,1,2,0,0, 1,0,1,2,0);
      add(0,1,3,0,0, 0,0,1,2,0);
      add(0,1,3,0,0, 1,0,1,3,0);
      add(0,1,4,0,0, 0,0,1,3,0);
      add(0,1,4,0,0, 1,0,1,4,0);
      add(0,1,6,0,0, 0,0,1,4,0);
      add(0,1,6,0,0, 0,0,1,4,0);
      add(0,1,6,1,1, 0,1,1,4,0);
      add(0,1,6,1,0, 0,1,2,3,0);
      add(0,1,6,1,0, 1,1,2,4,0);
      add(0,0,0,1,1, 0,1,2,4,0);
      add(0,0,0,1,1, 0,1,3,3,0);
      add(0,0,0,1,1, 0,1,4,2,0);
      add(0,0,0,1,1, 0,1,6,1,0);
      add(0,0,0,1,0, 0,0,0,0,0);
      // coalesce
      add(0,1,9,0,0, 0,0,0,0,0);
      add(0,1,9,0,0, 1,0,9,1,0);
      add(0,1,9,0,0, 0,0,9,1,0);
      add(0,1,9,0,0, 1,0,9,1,1);
      add(0,0,0,1,1, 0,1,9,1,0);
      add(0,0,0,1,0, 0,0,0,0,0);
      // same-cycle pop and push of the same number
      add(0,1,9,0,0, 0,0,0,0,0);
      add(0,1,9,0,0, 1,0,9,1,0);
      add(0,1,9,1,1, 0,1,9,1,0);
      add(0,1,9,1,0, 1,1,9,1,0);
      add(0,0,0,1,1, 0,1,9,1,0);
      add(0,0,0,1,0, 0,0,0,0,0);
      // flush with 7 waiting
      add(0,1,1,0,0, 0,0,0,0,0);
      add(0,1,1,0,0, 1,0,1,1,0);
      add(0,1,2,0,0, 0,0,1,1,0);
      add(0,1,2,0,0, 1,0,1,2,0);
      add(0,1,3,0,0, 0,0,1,2,0);
      add(0,1,3,0,0, 1,0,1,3,0);
      add(1,1,7,0,0, 0,0,1,3,0);
      add(0,1,7,0,0, 0,0,0,0,0);
      add(0,1,7,0,0, 1,0,7,1,0);
      add(0,0,0,1,1, 0,1,7,1,0);
      add(0,0,0,1,0, 0,0,0,0,0);

      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         flush     = vq[i].flush;
         irq_valid = vq[i].valid;
         irq_num   = vq[i].num;
         core_en   = vq[i].en;
         core_ack  = vq[i].cack;
         #1;
         chk($sformatf("row%0d ack", i),   32'(irq_ack),    32'(vq[i].e_ack));
         chk($sformatf("row%0d cv", i),    32'(core_valid), 32'(vq[i].e_cv));
         chk($sformatf("row%0d cnum", i),  32'(core_num),   32'(vq[i].e_num));
         chk($sformatf("row%0d count", i), 32'(pend_cnt),   32'(vq[i].e_cnt));
         chk($sformatf("row%0d coal", i),  32'(coal),       32'(vq[i].e_coal));
      end

      // asynchronous reset in the middle of a cycle with ack and coalesce high
      @(negedge clk);
      drive_idle();
      irq_valid = 1'b1; irq_num = 6'd3; core_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre-reset ack",   32'(irq_ack),  32'd1);
      chk("pre-reset coal",  32'(coal),     32'd1);
      chk("pre-reset count", 32'(pend_cnt), 32'd1);
      chk("pre-reset cnum",  32'(core_num), 32'd3);
      #1;
      rst = 1'b1;
      #1;
      chk_all_zero("async reset");
      drive_idle();
      @(negedge clk);
      rst = 1'b0;

      // streaming through pointer wrap with concurrent core acks
      sent   = 0;
      popped = 0;
      for (int cyc = 0; cyc < 200 && popped < 10; cyc++) begin
         @(negedge clk);
         irq_valid = (sent < 10);
         irq_num   = 6'(20 + sent);
         core_en   = 1'b1;
         core_ack  = (cyc % 3 != 0);
         #1;
         chk($sformatf("wrap cyc%0d count<=4", cyc), 32'(pend_cnt <= 3'd4), 32'd1);
         if (core_valid && core_ack) begin
            chk($sformatf("wrap pop%0d num", popped), 32'(core_num), 32'(20 + popped));
            popped++;
         end
         if (irq_ack) sent++;
      end
      chk("wrap all popped", 32'(popped), 32'd10);
      chk("wrap all sent",   32'(sent),   32'd10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/irq_receiver.md
Name: irq_receiver

Overview:
- Core-side end of the device IRQ interconnect.
- Accepts IRQ numbers from the interconnect's VALID/NUM/ACK output handshake and buffers them in a small FIFO.
- Coalesces repeats of an IRQ number that is already pending.
- Presents the oldest pending IRQ to the core exception unit, gated by the global interrupt enable.

Parameters:
- P_FIFO_DEPTH, 4, number of IRQ entries buffered; power of two, minimum 2.
- P_FIFO_DEPTH_N, 2, log2(P_FIFO_DEPTH); width of the FIFO pointers.

Ports:
- iCLOCK  input  1  system clock; all state changes on the rising edge.
- iRESET  input  1  asynchronous reset, active-high.
- iFLUSH  input  1  synchronous clear of all buffered state.
- iIRQ_VALID  input  1  interconnect IRQ request; held high until acknowledged.
- iIRQ_NUM  input  6  interconnect IRQ number; stable while iIRQ_VALID=1.
- oIRQ_ACK  output  1  one-cycle accept pulse to the interconnect.
- iCORE_IRQ_ENABLE  input  1  global interrupt enable from the core status register.
- oCORE_IRQ_VALID  output  1  pending IRQ offered to the core.
- oCORE_IRQ_NUM  output  6  number of the offered IRQ.
- iCORE_IRQ_ACK  input  1  core takes the offered IRQ.
- oPENDING_COUNT  output  P_FIFO_DEPTH_N+1  number of FIFO entries.
- oCOALESCE  output  1  one-cycle pulse: an accepted IRQ was merged into an existing entry.

Behaviour:
- Reset (iRESET=1, async): FIFO empty, read/write pointers 0, pending bitmap[63:0]=0, b_ack=0. Outputs: oIRQ_ACK=0, oCORE_IRQ_VALID=0, oCORE_IRQ_NUM=0, oPENDING_COUNT=0, oCOALESCE=0.
- iFLUSH=1: same clear as reset on the next edge; overrides every push, pop and accept in that cycle.
- Accept condition, evaluated each cycle: iIRQ_VALID && !b_ack && (count != P_FIFO_DEPTH).
  - The full test uses the count before any same-cycle pop.
  - When full, no ack is given and the interconnect holds VALID until space frees.
- On an accepted edge:
  - b_ack <= 1; oIRQ_ACK = b_ack, so the ACK pulse appears the cycle after sampling.
  - Same edge, unless coalescing: push iIRQ_NUM to the FIFO tail and set bitmap[iIRQ_NUM].
- While b_ack=1 the interconnect still drives VALID for that cycle; no accept is allowed. b_ack always clears on the next edge, so ACK is exactly one cycle wide.
- Coalesce: if bitmap[iIRQ_NUM]=1, and the cycle is not a pop whose head equals iIRQ_NUM:
  - ack normally, do not push, oCOALESCE=1 for one cycle (registered, aligned with oIRQ_ACK).
  - If the pending copy is popped in the same cycle, the new IRQ is pushed as a fresh entry.
- Core side:
  - oCORE_IRQ_VALID = iCORE_IRQ_ENABLE && count != 0.
  - oCORE_IRQ_NUM = FIFO head when count != 0, else 0.
- Pop: on oCORE_IRQ_VALID && iCORE_IRQ_ACK, advance the read pointer and clear bitmap[head].
  - iCORE_IRQ_ACK while oCORE_IRQ_VALID=0 is ignored.
- Enable low: entries are retained, VALID is masked, accepts continue up to full.
- Simultaneous push and pop: both take effect, count unchanged, pointers wrap modulo P_FIFO_DEPTH.
- Latency: IRQ sampled at edge t → entry visible to the core after edge t; oCORE_IRQ_VALID rises in cycle t+1.
- Ordering is strict FIFO; no priority reordering (the interconnect already arbitrated).
- oPENDING_COUNT = write count minus read count, range 0..P_FIFO_DEPTH.

Test Plan:
- Single IRQ: reset, enable=1, VALID with NUM=5 held until ACK.
  - Expect oIRQ_ACK exactly one cycle, 1 cycle after VALID first high; oCORE_IRQ_VALID=1 with NUM=5 from that cycle.
  - Core ACK → count returns to 0.
- Fill and backpressure: enable=0, send NUMs 1,2,3,4, then 6.
  - Expect 4 ACKs and count=4; NUM 6 gets no ACK while full.
  - Set enable=1 and core-ACK once → NUM 6 accepted and acked; pop order 1,2,3,4,6.
- Coalesce: enable=0, send 9 then 9 again.
  - Expect 2 ACKs, count=1, oCOALESCE pulse on the second; one pop yields 9 and count=0.
- Same-cycle pop and push of the same number: FIFO holds only 9 and enable=1; core ACK in the same cycle VALID=9 is sampled.
  - Expect no coalesce, count stays 1, head = 9.
- Flush and reset mid-operation: 3 entries queued with VALID=7 pending.
  - iFLUSH for 1 cycle → count=0, no ACK that cycle, 7 accepted afterwards.
  - iRESET asserted mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
- Wrap-around: stream 10 IRQs with concurrent core ACKs.
  - Order preserved across pointer wrap; count never exceeds 4.
